// File: rtl/mem_dump_pkg.sv
// Shared definitions for the memory read-back dumper: FSM state codes, UART frame
// constants and the CRC-8 byte update used when MEM_DUMP_CRC_EN is defined.
package mem_dump_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_SEND_HI = 3'd2;
  localparam logic [2:0] S_SEND_LO = 3'd3;
  localparam logic [2:0] S_NEXT    = 3'd4;
  localparam logic [2:0] S_CRC     = 3'd5;
  localparam logic [2:0] S_FINISH  = 3'd6;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // CRC-8, MSB first, whole byte folded in before the eight shift steps.
  function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/mem_uart_dumper_uart_tx_byte.sv
// UART 8N1 byte transmitter. A load may be issued while idle or in the cycle ready
// is high, so back-to-back frames come out with no idle gap.
module uart_tx_byte
  import mem_dump_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS + 1);

  logic          active_q, active_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    shift_q, shift_d;
  logic          bit_end;

  assign bit_end = active_q && (baud_q == BAUD_LAST);
  assign ready   = bit_end && (bit_q == BIT_LAST);
  assign tx      = active_q ? shift_q[0] : STOP_BIT;

  always_comb begin
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    if (load) begin
      active_d = 1'b1;
      baud_d   = '0;
      bit_d    = '0;
      shift_d  = {STOP_BIT, data, START_BIT};
    end else if (active_q) begin
      if (bit_end) begin
        baud_d = '0;
        if (ready) begin
          active_d = 1'b0;
        end else begin
          bit_d   = bit_q + 4'd1;
          shift_d = {STOP_BIT, shift_q[9:1]};
        end
      end else begin
        baud_d = baud_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '1;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
    end
  end

endmodule

// File: rtl/mem_uart_dumper.sv
// Walks the data memory and streams every word over UART, high byte first.
// Defining MEM_DUMP_CRC_EN appends a CRC-8 byte over everything sent.
module mem_uart_dumper
  import mem_dump_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       word_q, word_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              inflight_q, inflight_d;
  logic              tx_load, tx_ready, can_load;
  logic [7:0]        tx_data;
`ifdef MEM_DUMP_CRC_EN
  logic [7:0]        crc_q, crc_d;
`endif

  // The transmitter is free when nothing is in flight or its stop bit ends now.
  assign can_load = !inflight_q || tx_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tx_load = 1'b0;
    tx_data = word_q[15:8];
`ifdef MEM_DUMP_CRC_EN
    crc_d   = crc_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LOAD;
        busy_d  = 1'b1;
`ifdef MEM_DUMP_CRC_EN
        crc_d   = '0;
`endif
      end
      S_LOAD: begin
        word_d  = mem_rdata;
        state_d = S_SEND_HI;
      end
      S_SEND_HI: if (can_load) begin
        tx_load = 1'b1;
        tx_data = word_q[15:8];
        state_d = S_SEND_LO;
`ifdef MEM_DUMP_CRC_EN
        crc_d   = crc8_update(crc_q, word_q[15:8]);
`endif
      end
      S_SEND_LO: if (can_load) begin
        tx_load = 1'b1;
        tx_data = word_q[7:0];
        state_d = S_NEXT;
`ifdef MEM_DUMP_CRC_EN
        crc_d   = crc8_update(crc_q, word_q[7:0]);
`endif
      end
      S_NEXT: begin
        if (addr_q == ADDR_LAST) begin
`ifdef MEM_DUMP_CRC_EN
          state_d = S_CRC;
`else
          state_d = S_FINISH;
`endif
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_LOAD;
        end
      end
`ifdef MEM_DUMP_CRC_EN
      S_CRC: if (can_load) begin
        tx_load = 1'b1;
        tx_data = crc_q;
        state_d = S_FINISH;
      end
`endif
      S_FINISH: if (tx_ready) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        addr_d  = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    inflight_d = tx_load ? 1'b1 : (tx_ready ? 1'b0 : inflight_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      word_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef MEM_DUMP_CRC_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) crc_q <= '0;
    else        crc_q <= crc_d;
  end
`endif

  uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk   (clk),
    .reset (reset),
    .load  (tx_load),
    .data  (tx_data),
    .tx    (tx),
    .ready (tx_ready)
  );

  assign mem_addr  = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_uart_dumper.sv
// Bench for mem_uart_dumper: per-cycle capture of tx/busy/done for each dump, decoded
// against the byte stream expected from a memory snapshot (plus CRC-8 when enabled).
module tb_mem_uart_dumper;

  localparam int CLK_DIV = 4;
  localparam int ADDR_W  = 4;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int FRAME   = 10 * CLK_DIV;
`ifdef MEM_DUMP_CRC_EN
  localparam int NF = 2 * DEPTH + 1;
`else
  localparam int NF = 2 * DEPTH;
`endif
  localparam int DONE_AT = 2 + NF * FRAME;
  localparam int REC_LEN = DONE_AT + 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic              tx, busy, done;
  logic [2:0]        dbg_state;

  logic [15:0] mem [DEPTH];
  logic [7:0]  exp_q[$];
  logic        rec_tx [REC_LEN];
  logic        rec_busy [REC_LEN];
  logic        rec_done [REC_LEN];
  int          n_tests = 0;
  int          n_fail = 0;

  // clock / reset
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  mem_uart_dumper #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .tx        (tx),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bit-serial CRC-8 reference (poly 0x07, init 0, MSB first).
  function automatic logic [7:0] crc_ref(input logic [7:0] bytes[$]);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    foreach (bytes[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = c[7] ^ bytes[i][b];
        c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
    end
    return c;
  endfunction

  // driver: fill memory
  task automatic fill_mem(input int mode);
    for (int i = 0; i < DEPTH; i++) begin
      case (mode)
        0: mem[i] = 16'(i);
        1: mem[i] = (i == 3) ? 16'hA55A : 16'h0000;
        default: mem[i] = 16'($urandom_range(0, 65535));
      endcase
    end
  endtask

  // driver + capture: one dump with optional start re-pulse, memory write or reset.
  task automatic run_dump(input string name, input int reprobe_at, input int write_at,
                          input int reset_at);
    logic [7:0] exp_b [NF];
    logic [7:0] got;
    logic       want;
    int         shape_err, done_cnt, done_idx, busy_low;

    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(mem[i][15:8]);
      exp_q.push_back(mem[i][7:0]);
    end
`ifdef MEM_DUMP_CRC_EN
    exp_q.push_back(crc_ref(exp_q));
`endif
    for (int f = 0; f < NF; f++) exp_b[f] = exp_q[f];

    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < REC_LEN; i++) begin
      rec_tx[i]   = tx;
      rec_busy[i] = busy;
      rec_done[i] = done;
      if (i == write_at) mem[0] = 16'hFFFF;
      start = (i == reprobe_at);
      if (i == reset_at) begin
        reset = 1'b0;
        #1;
        check_eq({name, "_rst_tx"}, 32'(tx), 32'd1);
        check_eq({name, "_rst_busy"}, 32'(busy), 32'd0);
        check_eq({name, "_rst_addr"}, 32'(mem_addr), 32'd0);
        check_eq({name, "_rst_done"}, 32'(done), 32'd0);
        @(negedge clk); reset = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;

    // scoreboard: decode every frame from its mid-bit samples
    shape_err = 0;
    for (int f = 0; f < NF; f++) begin
      int base = 2 + f * FRAME;
      for (int b = 1; b <= 8; b++) got[b-1] = rec_tx[base + b * CLK_DIV + CLK_DIV / 2];
      check_eq($sformatf("%s_byte%0d", name, f), 32'(got), 32'(exp_q.pop_front()));
      for (int b = 0; b < 10; b++) begin
        want = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_b[f][b-1];
        for (int c = 0; c < CLK_DIV; c++)
          if (rec_tx[base + b * CLK_DIV + c] !== want) shape_err++;
      end
    end
    for (int i = 0; i < 2; i++) if (rec_tx[i] !== 1'b1) shape_err++;
    for (int i = DONE_AT; i < REC_LEN; i++) if (rec_tx[i] !== 1'b1) shape_err++;
    check_eq({name, "_bit_timing"}, 32'(shape_err), 32'd0);

    done_cnt = 0; done_idx = -1; busy_low = -1;
    for (int i = 0; i < REC_LEN; i++) begin
      if (rec_done[i] === 1'b1) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
      if (rec_busy[i] !== 1'b1 && busy_low < 0) busy_low = i;
    end
    check_eq({name, "_busy_early"}, 32'(rec_busy[0]), 32'd1);
    check_eq({name, "_done_count"}, 32'(done_cnt), 32'd1);
    check_eq({name, "_done_cycle"}, 32'(done_idx), 32'(DONE_AT));
    check_eq({name, "_busy_low_cycle"}, 32'(busy_low), 32'(DONE_AT));
    check_eq({name, "_addr_end"}, 32'(mem_addr), 32'd0);
  endtask

  initial begin
    fill_mem(0);
    repeat (3) @(negedge clk);
    check_eq("reset_tx", 32'(tx), 32'd1);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_addr", 32'(mem_addr), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    fill_mem(0); run_dump("ramp", -1, -1, -1);
    fill_mem(1); run_dump("a55a", -1, -1, -1);
    fill_mem(2); run_dump("reprobe", 2 + 5 * FRAME + 6, -1, -1);
    fill_mem(2); run_dump("abort", -1, -1, 2 + 10 * FRAME + 3 * CLK_DIV + 1);
    fill_mem(2); run_dump("redump", -1, -1, -1);
    fill_mem(0); run_dump("late_write", -1, 1, -1);
    for (int r = 0; r < 2; r++) begin
      fill_mem(2); run_dump($sformatf("rand%0d", r), -1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
